// File: rtl/core_req_pkg.sv
// -----------------------------------------------------------------------------
// core_req_pkg
// Shared types for the core-side request sequencer.
//   op_e    : command opcode carried in the command queue
//   state_e : sequencer FSM states
//   cmd_t   : command record at the default 32-bit address/data widths
// -----------------------------------------------------------------------------
package core_req_pkg;

  localparam int CORE_ADDR_WIDTH = 32;
  localparam int CORE_DATA_WIDTH = 32;
  localparam int CORE_STRB_WIDTH = CORE_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_FLUSH = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  typedef struct packed {
    op_e                        op;
    logic [CORE_ADDR_WIDTH-1:0] addr;
    logic [CORE_DATA_WIDTH-1:0] wdata;
    logic [CORE_STRB_WIDTH-1:0] wstrb;
    logic                       chk;
  } cmd_t;

endpackage

// File: rtl/core_req_seq_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO, no bypass. Pointers carry one extra wrap bit so full and
// empty are distinguished without a separate occupancy counter.
// Ports:
//   clk, rst   clock / asynchronous active-high reset
//   push_i     write request, accepted only when not full
//   pop_i      read request, honoured only when not empty
//   wdata_i    entry to write
//   rdata_o    head entry (valid while !empty_o)
//   full_o     all DEPTH entries in use
//   empty_o    no entries
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);

  // full_o is registered state, so a pop in the same cycle does not open a slot
  // for a push until the next cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // always_ff sees pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and leaving the array out of reset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/core_req_seq.sv
// -----------------------------------------------------------------------------
// core_req_seq
// Core-side initiator for the cache core port. Commands are queued, issued one
// at a time as single-cycle strobes, and completion is awaited on
// core_ready_i. Read data can be compared against an expected value under a
// byte mask. A missing completion halts the sequencer until reset.
// Ports:
//   clk, rst             clock / asynchronous active-high reset
//   cmd_valid_i/ready_o  command push handshake (ready = queue not full)
//   cmd_op_i             op_e opcode
//   cmd_addr_i           byte address
//   cmd_wdata_i          write data, or expected read data
//   cmd_wstrb_i          write strobes, or read compare byte mask
//   cmd_chk_i            enable read compare
//   core_addr/wdata/wstrb_o, core_write_o, core_read_o, cleanup_o
//                        request to cache, all zero outside the issue cycle
//   core_rdata_i         read data, valid while core_ready_i
//   core_ready_i         completion from cache
//   rsp_valid_o          one-cycle completion pulse
//   rsp_rdata_o          captured read data (0 for WRITE/FLUSH)
//   rsp_mismatch_o       qualifies rsp_valid_o: checked read differed
//   timeout_o            sticky, sequencer halted
//   busy_o               queue non-empty or FSM not idle
//   done_cnt_o/err_cnt_o saturating completion / error counters
// -----------------------------------------------------------------------------
module core_req_seq
  import core_req_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [1:0]              cmd_op_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
  input  logic                    cmd_chk_i,
  output logic [ADDR_WIDTH-1:0]   core_addr_o,
  output logic [DATA_WIDTH-1:0]   core_wdata_o,
  output logic [DATA_WIDTH/8-1:0] core_wstrb_o,
  output logic                    core_write_o,
  output logic                    core_read_o,
  output logic                    cleanup_o,
  input  logic [DATA_WIDTH-1:0]   core_rdata_i,
  input  logic                    core_ready_i,
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_mismatch_o,
  output logic                    timeout_o,
  output logic                    busy_o,
  output logic [CNT_WIDTH-1:0]    done_cnt_o,
  output logic [CNT_WIDTH-1:0]    err_cnt_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int TW         = $clog2(TIMEOUT) + 1;

  // Queue entry at this instance's widths.
  typedef struct packed {
    op_e                   op;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  chk;
  } req_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [STRB_WIDTH-1:0] strb);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int b = 0; b < STRB_WIDTH; b++) m[b*8 +: 8] = {8{strb[b]}};
    return m;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Command queue
  // ---------------------------------------------------------------------------
  req_t push_cmd, head;
  logic fifo_full, fifo_empty, fifo_pop;

  assign push_cmd = '{op:    op_e'(cmd_op_i),
                      addr:  cmd_addr_i,
                      wdata: cmd_wdata_i,
                      wstrb: cmd_wstrb_i,
                      chk:   cmd_chk_i};

  sync_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid_i),
    .pop_i   (fifo_pop),
    .wdata_i (push_cmd),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_e                state_q;
  op_e                   op_q;
  logic [DATA_WIDTH-1:0] exp_q;
  logic [STRB_WIDTH-1:0] mask_q;
  logic                  chk_q;
  logic [TW-1:0]         timer_q;

  logic [ADDR_WIDTH-1:0] core_addr_q;
  logic [DATA_WIDTH-1:0] core_wdata_q;
  logic [STRB_WIDTH-1:0] core_wstrb_q;
  logic                  core_write_q, core_read_q, cleanup_q;
  logic                  rsp_valid_q, rsp_mismatch_q, timeout_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [CNT_WIDTH-1:0]  done_cnt_q, err_cnt_q;

  logic                  rsp_mismatch_d;

  // The head is popped on the IDLE cycle it is seen; NOPs retire right there.
  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

  // Only a checked READ can mismatch; unmasked bytes never count.
  assign rsp_mismatch_d = chk_q && (op_q == OP_READ) &&
                          (|((core_rdata_i ^ exp_q) & byte_mask(mask_q)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      op_q           <= OP_NOP;
      exp_q          <= '0;
      mask_q         <= '0;
      chk_q          <= 1'b0;
      timer_q        <= '0;
      core_addr_q    <= '0;
      core_wdata_q   <= '0;
      core_wstrb_q   <= '0;
      core_write_q   <= 1'b0;
      core_read_q    <= 1'b0;
      cleanup_q      <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_mismatch_q <= 1'b0;
      timeout_q      <= 1'b0;
      done_cnt_q     <= '0;
      err_cnt_q      <= '0;
    end else begin
      // Strobes and the request bus are high only during ISSUE, and the
      // response flags only during RESP; everything else drops back to 0.
      core_addr_q    <= '0;
      core_wdata_q   <= '0;
      core_wstrb_q   <= '0;
      core_write_q   <= 1'b0;
      core_read_q    <= 1'b0;
      cleanup_q      <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_mismatch_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty && head.op != OP_NOP) begin
            op_q    <= head.op;
            exp_q   <= head.wdata;
            mask_q  <= head.wstrb;
            chk_q   <= head.chk;
            state_q <= ST_ISSUE;
            // Request outputs are loaded here so they are registered and
            // valid for exactly the ISSUE cycle.
            case (head.op)
              OP_WRITE: begin
                core_write_q <= 1'b1;
                core_addr_q  <= head.addr;
                core_wdata_q <= head.wdata;
                core_wstrb_q <= head.wstrb;
              end
              OP_READ: begin
                core_read_q  <= 1'b1;
                core_addr_q  <= head.addr;
                core_wdata_q <= head.wdata;
              end
              default: cleanup_q <= 1'b1;
            endcase
          end
        end

        ST_ISSUE: begin
          timer_q <= '0;
          state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          if (core_ready_i) begin
            rsp_valid_q    <= 1'b1;
            rsp_rdata_q    <= (op_q == OP_READ) ? core_rdata_i : '0;
            rsp_mismatch_q <= rsp_mismatch_d;
            done_cnt_q     <= sat_inc(done_cnt_q);
            if (rsp_mismatch_d) err_cnt_q <= sat_inc(err_cnt_q);
            state_q        <= ST_RESP;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            err_cnt_q <= sat_inc(err_cnt_q);
            state_q   <= ST_HALT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        ST_RESP: state_q <= ST_IDLE;

        // Terminal until reset; late completions are ignored.
        ST_HALT: state_q <= ST_HALT;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cmd_ready_o    = !fifo_full;
  assign busy_o         = !fifo_empty || (state_q != ST_IDLE);
  assign core_addr_o    = core_addr_q;
  assign core_wdata_o   = core_wdata_q;
  assign core_wstrb_o   = core_wstrb_q;
  assign core_write_o   = core_write_q;
  assign core_read_o    = core_read_q;
  assign cleanup_o      = cleanup_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rsp_rdata_q;
  assign rsp_mismatch_o = rsp_mismatch_q;
  assign timeout_o      = timeout_q;
  assign done_cnt_o     = done_cnt_q;
  assign err_cnt_o      = err_cnt_q;

endmodule
